// File: rtl/log2_pkg.sv
// Shared constants and helpers for the log2 approximation datapath (Q4.12 fixed point).
package log2_pkg;

    localparam int unsigned Q_FRAC = 12;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] LOG2_SAT_NEG = 16'h8000;
    localparam logic [DATA_W-1:0] ONE          = 16'h1000;

    // log2 is undefined for zero and negative operands.
    function automatic logic operand_invalid(input logic [DATA_W-1:0] x);
        return (x == '0) || x[DATA_W-1];
    endfunction

endpackage

// File: rtl/log2_approx.sv
// Combinational piecewise-linear log2: exponent from the leading one, fraction from the
// mantissa bits below it. Results below the Q4.12 range saturate to the most negative code.
module log2_approx
    import log2_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    output logic [DATA_W-1:0] y_o
);

    logic [3:0]        msb;
    logic [3:0]        shamt;
    logic [3:0]        expo;
    logic [Q_FRAC-1:0] frac;

    always_comb begin
        msb = '0;
        for (int i = 0; i < DATA_W - 1; i++) begin
            if (x_i[i]) begin
                msb = 4'(i);
            end
        end
        shamt = 4'(DATA_W - 2) - msb;
        // Normalise the leading one to bit 14; bits 13:2 are then the fraction.
        frac  = Q_FRAC'((x_i[DATA_W-2:0] << shamt) >> 2);
        expo  = msb - 4'(Q_FRAC);
        if (x_i[DATA_W-1] || (msb < 4'(Q_FRAC - 8))) begin
            y_o = LOG2_SAT_NEG;
        end else begin
            y_o = {expo, frac};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above ptr_i, wrapping to zero.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] cand;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (IDX_W'(i) >= ptr_i);
        end
    end

    assign hi_req = req_i & hi_mask;
    assign cand   = (|hi_req) ? hi_req : req_i;

    // Descending scan so the lowest candidate index wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (en_i && cand[i]) begin
                gnt_o     = '0;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
            end
        end
    end

    assign gnt_valid_o = |gnt_o;

endmodule

// File: rtl/log2_share_arb.sv
// Shares one log2_approx between NUM_REQ requesters through a round-robin arbiter and a
// two-stage elastic pipeline with a single backpressured response channel.
module log2_share_arb
    import log2_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic              s2_err_q, s2_err_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               adv1, adv2;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  approx_y;

    assign adv2 = ~s2_valid_q | resp_ready;
    assign adv1 = ~s1_valid_q | adv2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .en_i        (adv1 & ~rst),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    log2_approx u_log2 (
        .x_i (s1_data_q),
        .y_o (approx_y)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_err_d   = s2_err_q;
        rr_ptr_d   = rr_ptr_q;

        if (adv1) begin
            s1_valid_d = gnt_valid;
            if (gnt_valid) begin
                s1_data_d = sel_data;
                s1_id_d   = gnt_idx;
                rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d = s1_id_q;
                if (operand_invalid(s1_data_q)) begin
                    s2_data_d = LOG2_SAT_NEG;
                    s2_err_d  = 1'b1;
                end else begin
                    s2_data_d = approx_y;
                    s2_err_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_err_q   <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_err_q   <= s2_err_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = s2_valid_q;
    assign resp_data  = s2_data_q;
    assign resp_id    = s2_id_q;
    assign resp_err   = s2_err_q;

endmodule

// File: tb/tb_log2_share_arb.sv
// Bench for log2_share_arb: transaction-level model of arbitration and pipeline occupancy,
// directed scenarios with literal expectations, then randomized valid/ready stress.
module tb_log2_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [15:0]             dat [NUM_REQ];
    logic [16*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [15:0]             resp_data;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_data[g*16 +: 16] = dat[g];
    end

    log2_share_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [15:0] data;
        int          id;
        logic        err;
        int          st;
    } item_t;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
    } obs_t;

    item_t              mq[$];
    obs_t               obs[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 ptr = 0;
    int                 waits[NUM_REQ];
    int                 acc_total = 0;
    logic [NUM_REQ-1:0] acc_seen = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: log2(x/4096) = e + m, x = 2^p * (1 + m), e = p - 12; {err, data}.
    function automatic logic [16:0] ref_log2(input logic [15:0] x);
        int v, p, r;
        v = int'(x);
        if (v == 0 || v >= 32768) return {1'b1, 16'h8000};
        p = 0;
        while ((2 ** (p + 1)) <= v) p++;
        r = (p - 12) * 4096 + ((v - 2 ** p) * 4096) / (2 ** p);
        if (r < -32768) r = -32768;
        return {1'b0, r[15:0]};
    endfunction

    function automatic logic [15:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 16'h0000;
        if (sel == 1) return 16'h8000 | 16'($urandom);
        if (sel == 2) return 16'($urandom_range(1, 15));
        return 16'($urandom_range(1, 32767));
    endfunction

    task automatic model_cycle();
        int          n, pg, idx;
        bit          s2f, s1f, a2, a1;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [16:0] r;
        item_t       it;

        n   = mq.size();
        s2f = (n > 0) && (mq[0].st == 2);
        s1f = (n > 0) && (mq[n-1].st == 1);
        a2  = !s2f || resp_ready;
        a1  = !s1f || a2;
        pg  = -1;
        if (!rst && a1) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (ptr + k) % NUM_REQ;
                if (pg < 0 && req_valid[idx]) pg = idx;
            end
        end
        exp_rdy = '0;
        if (pg >= 0) exp_rdy[pg] = 1'b1;

        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(s2f));
        if (s2f) begin
            check("resp_data", 32'(resp_data), 32'(mq[0].data));
            check("resp_id", 32'(resp_id), 32'(mq[0].id));
            check("resp_err", 32'(resp_err), 32'(mq[0].err));
        end

        if (resp_valid && resp_ready) obs.push_back('{int'(resp_id), resp_data, resp_err});
        acc_seen = req_valid & req_ready;

        if (rst) begin
            mq.delete();
            ptr = 0;
            for (int j = 0; j < NUM_REQ; j++) waits[j] = 0;
        end else begin
            acc_total += $countones(acc_seen);
            // Fairness: a pending requester sees at most NUM_REQ-1 other grants.
            if (acc_seen != '0) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (acc_seen[j]) begin
                        check("wait_bound", 32'(waits[j] <= NUM_REQ - 1), 32'd1);
                        waits[j] = 0;
                    end else if (req_valid[j]) begin
                        waits[j]++;
                    end
                end
            end
            if (s2f && resp_ready) void'(mq.pop_front());
            if (s1f && a2) begin
                it    = mq.pop_back();
                it.st = 2;
                mq.push_back(it);
            end
            if (pg >= 0) begin
                r = ref_log2(dat[pg]);
                mq.push_back('{r[15:0], pg, r[16], 1});
                ptr = (pg + 1) % NUM_REQ;
            end
        end
    endtask

    initial begin
        for (int j = 0; j < NUM_REQ; j++) waits[j] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Retire outstanding requests without withdrawing any, then empty the pipeline.
    task automatic drain(input int bound);
        resp_ready = 1'b1;
        for (int c = 0; c < bound && req_valid != '0; c++) begin
            step();
            req_valid &= ~acc_seen;
        end
        check("drain_done", 32'(req_valid), 32'd0);
        repeat (4) step();
    endtask

    logic [15:0] tdat [NUM_REQ];
    logic [15:0] tres [NUM_REQ];
    int          cnt, base;
    bit          first;

    initial begin
        tdat = '{16'h1000, 16'h2000, 16'h4000, 16'h0800};
        tres = '{16'h0000, 16'h1000, 16'h2000, 16'hF000};
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) dat[j] = '0;
        step();
        step();

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Single request 2.0 -> 1.0, visible two cycles after the request cycle
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dat[0]     = 16'h2000;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_lat_valid0", 32'(resp_valid), 32'd0);
        step();
        @(negedge clk);
        check("t1_valid", 32'(resp_valid), 32'd1);
        check("t1_data", 32'(resp_data), 32'h1000);
        check("t1_id", 32'(resp_id), 32'd0);
        check("t1_err", 32'(resp_err), 32'd0);
        step();

        // All requesters continuously valid: round-robin order and results
        do_reset();
        obs.delete();
        for (int j = 0; j < NUM_REQ; j++) dat[j] = tdat[j];
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
            step();
        end
        drain(16);
        check("t2_count", 32'(obs.size() >= 8), 32'd1);
        if (obs.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t2_id", 32'(obs[k].id), 32'(k % 4));
                check("t2_data", 32'(obs[k].data), 32'(tres[k % 4]));
            end
        end

        // Backpressure: exactly two items held, then drained in order
        do_reset();
        obs.delete();
        req_valid  = '1;
        resp_ready = 1'b0;
        cnt        = 0;
        repeat (5) begin
            step();
            cnt += $countones(acc_seen);
        end
        check("t3_accepted", 32'(cnt), 32'd2);
        @(negedge clk);
        check("t3_ready_low", 32'(req_ready), 32'd0);
        check("t3_hold_valid", 32'(resp_valid), 32'd1);
        check("t3_hold_id", 32'(resp_id), 32'd0);
        check("t3_hold_data", 32'(resp_data), 32'h0000);
        @(posedge clk);
        #1;
        drain(16);
        check("t3_drained", 32'(obs.size() >= 2), 32'd1);
        if (obs.size() >= 2) begin
            check("t3_first_id", 32'(obs[0].id), 32'd0);
            check("t3_second_id", 32'(obs[1].id), 32'd1);
            check("t3_second_data", 32'(obs[1].data), 32'h1000);
        end

        // Invalid operands from requester 2
        do_reset();
        obs.delete();
        resp_ready = 1'b1;
        dat[2]     = 16'h0000;
        req_valid  = 4'b0100;
        first      = 1'b1;
        for (int c = 0; c < 10 && req_valid[2]; c++) begin
            step();
            if (acc_seen[2]) begin
                if (first) begin
                    dat[2] = 16'hF000;
                    first  = 1'b0;
                end else begin
                    req_valid[2] = 1'b0;
                end
            end
        end
        repeat (4) step();
        check("t4_count", 32'(obs.size()), 32'd2);
        foreach (obs[k]) begin
            check("t4_id", 32'(obs[k].id), 32'd2);
            check("t4_err", 32'(obs[k].err), 32'd1);
            check("t4_data", 32'(obs[k].data), 32'h8000);
        end

        // Reset with both stages full discards them
        do_reset();
        for (int j = 0; j < NUM_REQ; j++) dat[j] = tdat[j];
        req_valid  = '1;
        resp_ready = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        step();
        rst        = 1'b0;
        resp_ready = 1'b1;
        obs.delete();
        base       = acc_total;
        @(negedge clk);
        check("t5_valid_cleared", 32'(resp_valid), 32'd0);
        check("t5_ptr_zero", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        drain(16);
        check("t5_no_stale", 32'(obs.size()), 32'(acc_total - base));
        if (obs.size() > 0) check("t5_first_id", 32'(obs[0].id), 32'd0);

        // Randomized stress
        obs.delete();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && acc_seen[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    dat[i]       = rand_operand();
                    req_valid[i] = 1'b1;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(64);
        @(negedge clk);
        check("final_empty", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
